// File: rtl/core_cache_responder.sv
// core_cache_responder: single-outstanding cache-line responder with a small
// line store. Requests are acknowledged with a one-cycle reqack; reads (and,
// when CCR_WRITE_RESP_EN is defined, writes) answer with a held respcyc after
// a fixed latency. Only MEMORY-type writes update the store; non-MEMORY
// reads return an all-zero line.
// Optional feature macro: CCR_WRITE_RESP_EN (writes also produce a response).
// DEPTH must be a power of two, at least 2.
module core_cache_responder #(
    parameter int DATA_WIDTH = 512,
    parameter int ADDRESS    = 64,
    parameter int TAG_WIDTH  = 13,
    parameter int DEPTH      = 16,
    parameter int LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDRESS-1:0]    req,
    input  logic [DATA_WIDTH-1:0] reqdata,
    input  logic [TAG_WIDTH-1:0]  reqtag,
    input  logic                  reqcyc,
    output logic                  reqack,
    output logic [DATA_WIDTH-1:0] resp,
    output logic [TAG_WIDTH-1:0]  resptag,
    output logic                  respcyc,
    input  logic                  respack
);

    localparam int         IDX_W       = $clog2(DEPTH);
    localparam logic [3:0] TYPE_MEMORY = 4'b0001;
    localparam logic [3:0] LAT         = 4'(LATENCY);

    typedef enum logic [1:0] {IDLE, ACK, WAIT, RESP} state_t;

    state_t                state;
    logic [3:0]            count;
    logic [IDX_W-1:0]      idx;
    logic [DATA_WIDTH-1:0] line;
    logic [TAG_WIDTH-1:0]  tag;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  is_read;
    logic                  is_mem;
    logic                  needs_resp;
    logic                  accept;
    logic [DATA_WIDTH-1:0] read_line;
    logic                  unused_addr_bits;

    // Address offset bits and bits above the index never select a line.
    assign unused_addr_bits = ^{req[ADDRESS-1:6+IDX_W], req[5:0]};

    assign is_read   = tag[TAG_WIDTH-1];
    assign is_mem    = (tag[TAG_WIDTH-2 -: 4] == TYPE_MEMORY);
    assign accept    = (state == IDLE) && reqcyc;
    assign read_line = (is_read && is_mem) ? mem[idx] : '0;

`ifdef CCR_WRITE_RESP_EN
    assign needs_resp = 1'b1;
`else
    assign needs_resp = is_read;
`endif

    // Capture the request payload when it is accepted; it is only consumed
    // while a transaction is in flight, so it needs no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            idx  <= req[6 +: IDX_W];
            line <= reqdata;
            tag  <= reqtag;
        end
    end

    // Line store: MEMORY writes commit on the ACK-cycle edge; contents survive reset.
    always_ff @(posedge clk) begin
        if (reset && (state == ACK) && !is_read && is_mem) begin
            mem[idx] <= line;
        end
    end

    // Transaction FSM with registered handshake and response outputs.
    // The counter is loaded with LATENCY on acceptance and counts down on
    // every ACK/WAIT edge, so respcyc rises LATENCY cycles after reqack.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            count   <= 4'd0;
            reqack  <= 1'b0;
            respcyc <= 1'b0;
            resp    <= '0;
            resptag <= '0;
        end else begin
            reqack <= 1'b0;
            case (state)
                IDLE: begin
                    if (reqcyc) begin
                        state  <= ACK;
                        reqack <= 1'b1;
                        count  <= LAT;
                    end
                end
                ACK, WAIT: begin
                    if ((state == ACK) && !needs_resp) begin
                        state <= IDLE;
                        count <= 4'd0;
                    end else if (count == 4'd1) begin
                        state   <= RESP;
                        count   <= 4'd0;
                        respcyc <= 1'b1;
                        resp    <= read_line;
                        resptag <= tag;
                    end else begin
                        state <= WAIT;
                        count <= count - 4'd1;
                    end
                end
                RESP: begin
                    if (respack) begin
                        state   <= IDLE;
                        respcyc <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
